// File: rtl/ifetch_q_if.sv
// Instruction-memory read bus for the prefetch queue.
// Carries a single-outstanding req/ack handshake with the address and data.
interface ifetch_q_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          im_req;
    logic [AW-1:0] im_addr;
    logic          im_ack;
    logic [DW-1:0] im_data;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_data
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_data
    );
endinterface

// File: rtl/ifetch_q.sv
// Instruction prefetch queue: fetches sequential words into a PC-tagged FIFO and flushes on redirect.
// Optional statistics counters (fetch_cnt, flush_cnt) are built when IFQ_STATS_EN is defined.
module ifetch_q #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_f,
    ifetch_q_if.master               mem,
    input  logic                     deq,
    output logic [DW-1:0]            instr,
    output logic [AW-1:0]            instr_pc,
    output logic                     instr_vld,
    input  logic                     redir,
    input  logic [AW-1:0]            redir_addr,
    output logic [$clog2(DEPTH):0]   q_cnt
`ifdef IFQ_STATS_EN
    ,
    output logic [15:0]              fetch_cnt,
    output logic [15:0]              flush_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] fpc;
    logic [AW-1:0] fpc_nxt;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;

    logic [DW-1:0] data_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];

    // A word is kept only when acked in REQ without a redirect; redirect also cancels any pop.
    always_comb begin
        push    = (state == REQ) && mem.im_ack && !redir;
        pop     = deq && (cnt != '0) && !redir;
        cnt_nxt = cnt;
        if (redir) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state  <= IDLE;
            fpc    <= '0;
            addr_q <= '0;
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            fpc    <= fpc_nxt;
            addr_q <= addr_nxt;
            cnt    <= cnt_nxt;
            if (redir) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= mem.im_data;
            pc_mem[wr_ptr]   <= addr_q;
        end
    end

    // In REQ the held address always equals fpc, so the back-to-back address is fpc+1.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        fpc_nxt   = fpc;
        case (state)
            IDLE: begin
                if (redir) begin
                    state_nxt = REQ;
                    addr_nxt  = redir_addr;
                end else if (cnt < FULL) begin
                    state_nxt = REQ;
                    addr_nxt  = fpc;
                end
            end
            REQ: begin
                if (redir) begin
                    if (mem.im_ack) begin
                        state_nxt = REQ;
                        addr_nxt  = redir_addr;
                    end else begin
                        state_nxt = DROP;
                    end
                end else if (mem.im_ack) begin
                    fpc_nxt = fpc + 1'b1;
                    if (cnt_nxt < FULL) begin
                        state_nxt = REQ;
                        addr_nxt  = fpc + 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (mem.im_ack) begin
                    state_nxt = REQ;
                    addr_nxt  = redir ? redir_addr : fpc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (redir) begin
            fpc_nxt = redir_addr;
        end
    end

    always_comb begin
        mem.im_req = (state != IDLE);
        instr_vld  = (cnt != '0);
        instr      = '0;
        instr_pc   = '0;
        if (cnt != '0) begin
            instr    = data_mem[rd_ptr];
            instr_pc = pc_mem[rd_ptr];
        end
    end

    assign mem.im_addr = addr_q;
    assign q_cnt       = cnt;

`ifdef IFQ_STATS_EN
    // Any ack that completes a real request counts, whether its data was kept or dropped.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mem.im_ack && (state != IDLE)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (redir) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
